// File: rtl/div_arb_pkg.sv
// Shared types and default sizing for the shared-divider arbiter.
package div_arb_pkg;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_THREADS = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_serial_divider.sv
// Iterative restoring divider: one quotient bit per enabled step, WIDTH steps.
// The dividend register doubles as the quotient register: dividend bits shift out
// of the top while quotient bits shift in at the bottom.
// A zero divisor needs no special case. Every compare succeeds, so the quotient
// is all ones and the dividend bits shift straight into the remainder.
module alu_serial_divider
   import div_arb_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_step,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_last_step
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_dq;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH:0]   w_rem_sh;
   logic             w_ge;

   // The shifted partial remainder is one bit wider than the operands so that
   // it can be compared against the divisor before the subtraction.
   assign w_rem_sh = {r_rem, r_dq[WIDTH-1]};
   assign w_ge     = (w_rem_sh >= {1'b0, r_div});

   // Load operands on start, then perform one restoring step per enabled cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
         r_rem <= '0;
         r_dq  <= '0;
         r_div <= '0;
      end else if (i_load) begin
         r_cnt <= '0;
         r_rem <= '0;
         r_dq  <= i_dividend;
         r_div <= i_divisor;
      end else if (i_step) begin
         r_rem <= w_ge ? WIDTH'(w_rem_sh - {1'b0, r_div}) : w_rem_sh[WIDTH-1:0];
         r_dq  <= {r_dq[WIDTH-2:0], w_ge};
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_quotient  = r_dq;
   assign o_remainder = r_rem;
   assign o_last_step = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/alu_div_arbiter.sv
// Round-robin arbiter sharing one serial divider between per-thread ALUs.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  S_IDLE | waiting for any request; grants the first requester at/after rr_ptr
//  S_BUSY | divider stepping, one quotient bit per enabled cycle
//  S_DONE | done[owner] pulses with quotient/remainder; rr_ptr advances on exit
//
// enable=0 freezes every register, so a done cycle is simply held.
module alu_div_arbiter
   import div_arb_pkg::*;
#(
   parameter  int THREADS = DEF_THREADS,
   parameter  int WIDTH   = DEF_WIDTH,
   localparam int OW      = $clog2(THREADS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [THREADS-1:0]       req,
   input  logic [THREADS*WIDTH-1:0] rs_flat,
   input  logic [THREADS*WIDTH-1:0] rt_flat,
   output logic [THREADS-1:0]       done,
   output logic [WIDTH-1:0]         quotient,
   output logic [WIDTH-1:0]         remainder,
   output logic                     busy,
   output logic [OW-1:0]            owner
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [OW-1:0]    r_owner;
   logic [OW-1:0]    r_rr_ptr;
   logic [OW-1:0]    w_pick;
   logic             w_found;
   logic             w_load;
   logic             w_step;
   logic [WIDTH-1:0] w_rs_sel;
   logic [WIDTH-1:0] w_rt_sel;
   logic [WIDTH-1:0] w_div_q;
   logic [WIDTH-1:0] w_div_r;
   logic             w_last;

   // Round-robin pick: first requesting thread at or above rr_ptr, wrapping.
   always_comb begin
      w_pick  = '0;
      w_found = 1'b0;
      for (int k = 0; k < THREADS; k++) begin
         if (!w_found && req[(int'(r_rr_ptr) + k) % THREADS]) begin
            w_found = 1'b1;
            w_pick  = OW'((int'(r_rr_ptr) + k) % THREADS);
         end
      end
   end

   assign w_rs_sel = rs_flat[int'(w_pick)*WIDTH +: WIDTH];
   assign w_rt_sel = rt_flat[int'(w_pick)*WIDTH +: WIDTH];
   assign w_load   = enable && (r_state == S_IDLE) && w_found;
   assign w_step   = enable && (r_state == S_BUSY);

   alu_serial_divider #(
      .WIDTH (WIDTH)
   ) u_div (
      .clk         (clk),
      .reset       (reset),
      .i_load      (w_load),
      .i_step      (w_step),
      .i_dividend  (w_rs_sel),
      .i_divisor   (w_rt_sel),
      .o_quotient  (w_div_q),
      .o_remainder (w_div_r),
      .o_last_step (w_last)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state decode; every transition is gated by enable.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_load)           w_state_nxt = S_BUSY;
         S_BUSY:  if (enable && w_last) w_state_nxt = S_DONE;
         S_DONE:  if (enable)           w_state_nxt = S_IDLE;
         default:                       w_state_nxt = S_IDLE;
      endcase
   end

   // Owner latches at grant; rr_ptr moves past the owner as the done cycle ends.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_owner  <= '0;
         r_rr_ptr <= '0;
      end else begin
         if (w_load) r_owner <= w_pick;
         if (enable && (r_state == S_DONE))
            r_rr_ptr <= (r_owner == OW'(THREADS - 1)) ? '0 : r_owner + OW'(1);
      end
   end

   // Result outputs are only non-zero during the done cycle.
   always_comb begin
      done      = '0;
      quotient  = '0;
      remainder = '0;
      if (r_state == S_DONE) begin
         done[r_owner] = 1'b1;
         quotient      = w_div_q;
         remainder     = w_div_r;
      end
   end

   assign busy  = (r_state != S_IDLE);
   assign owner = r_owner;

endmodule

// File: tb/tb_alu_div_arbiter.sv
// Self-checking bench for alu_div_arbiter: directed scenarios plus randomized
// request/operand mixes compared against an arithmetic reference model.
module tb_alu_div_arbiter;

   localparam int T  = 4;
   localparam int W  = 8;
   localparam int OW = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic [T-1:0]     req;
   logic [T*W-1:0]   rs_flat;
   logic [T*W-1:0]   rt_flat;
   logic [T-1:0]     done;
   logic [W-1:0]     quotient;
   logic [W-1:0]     remainder;
   logic             busy;
   logic [OW-1:0]    owner;

   int checks = 0;
   int errors = 0;
   int m_rr   = 0;

   alu_div_arbiter #(.THREADS(T), .WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .req       (req),
      .rs_flat   (rs_flat),
      .rt_flat   (rt_flat),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .busy      (busy),
      .owner     (owner)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == 0) return {W{1'b1}};
      return a / b;
   endfunction

   function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == 0) return a;
      return a % b;
   endfunction

   function automatic int ref_pick(input logic [T-1:0] m, input int rr);
      for (int k = 0; k < T; k++)
         if (m[(rr + k) % T]) return (rr + k) % T;
      return -1;
   endfunction

   task automatic set_ops(input int t, input logic [W-1:0] a, input logic [W-1:0] b);
      rs_flat[t*W +: W] = a;
      rt_flat[t*W +: W] = b;
   endtask

   // Cycles from the current negedge until done is seen (999 when it never comes).
   task automatic wait_done(output int cyc);
      bit got;
      got = 1'b0;
      cyc = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         if (done != 0) got = 1'b1;
      end
      if (!got) cyc = 999;
   endtask

   task automatic do_reset;
      @(negedge clk);
      reset = 1'b1;
      req   = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      m_rr  = 0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (done !== '0)      begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (quotient !== '0)  begin errors++; $display("FAIL reset_q: got %0d want 0", quotient); end
      checks++; if (remainder !== '0) begin errors++; $display("FAIL reset_r: got %0d want 0", remainder); end
      checks++; if (owner !== '0)     begin errors++; $display("FAIL reset_owner: got %0d want 0", owner); end
      reset = 1'b0;
      m_rr  = 0;
      @(negedge clk);
   endtask

   task automatic test_single;
      int c;
      set_ops(0, 8'd200, 8'd7);
      req = 4'b0001;
      wait_done(c);
      checks++; if (c != 9)             begin errors++; $display("FAIL single_lat: got %0d want 9", c); end
      checks++; if (done !== 4'b0001)   begin errors++; $display("FAIL single_done: got %b want 0001", done); end
      checks++; if (quotient !== 8'd28) begin errors++; $display("FAIL single_q: got %0d want 28", quotient); end
      checks++; if (remainder !== 8'd4) begin errors++; $display("FAIL single_r: got %0d want 4", remainder); end
      checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
      req  = '0;
      m_rr = 1;
      @(negedge clk);
      checks++; if (done !== '0)     begin errors++; $display("FAIL single_done_clr: got %b want 0", done); end
      checks++; if (quotient !== '0) begin errors++; $display("FAIL single_q_clr: got %0d want 0", quotient); end
   endtask

   task automatic test_div_zero;
      int c;
      set_ops(1, 8'd93, 8'd0);
      req = 4'b0010;
      wait_done(c);
      checks++; if (c != 9)              begin errors++; $display("FAIL dz_lat: got %0d want 9", c); end
      checks++; if (done !== 4'b0010)    begin errors++; $display("FAIL dz_done: got %b want 0010", done); end
      checks++; if (quotient !== 8'd255) begin errors++; $display("FAIL dz_q: got %0d want 255", quotient); end
      checks++; if (remainder !== 8'd93) begin errors++; $display("FAIL dz_r: got %0d want 93", remainder); end
      req  = '0;
      m_rr = 2;
      @(negedge clk);
   endtask

   task automatic test_fairness;
      int c, lat, exp;
      logic [W-1:0] av[T];
      logic [W-1:0] bv[T];
      do_reset();
      for (int t = 0; t < T; t++) begin
         av[t] = W'($urandom);
         bv[t] = W'($urandom_range(1, 255));
         set_ops(t, av[t], bv[t]);
      end
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp = k % T;
         if (k > 0) begin
            @(posedge clk);
            @(negedge clk);
            req[(k - 1) % T] = 1'b1;
         end
         wait_done(c);
         lat = (k == 0) ? c : c + 1;
         checks++; if (lat != ((k == 0) ? 9 : 10)) begin errors++; $display("FAIL fair_lat[%0d]: got %0d want %0d", k, lat, (k == 0) ? 9 : 10); end
         checks++; if (owner !== OW'(exp))          begin errors++; $display("FAIL fair_owner[%0d]: got %0d want %0d", k, owner, exp); end
         checks++; if (done !== T'(1 << exp))       begin errors++; $display("FAIL fair_done[%0d]: got %b want %b", k, done, T'(1 << exp)); end
         checks++; if (quotient !== ref_q(av[exp], bv[exp]))  begin errors++; $display("FAIL fair_q[%0d]: got %0d want %0d", k, quotient, ref_q(av[exp], bv[exp])); end
         checks++; if (remainder !== ref_r(av[exp], bv[exp])) begin errors++; $display("FAIL fair_r[%0d]: got %0d want %0d", k, remainder, ref_r(av[exp], bv[exp])); end
         req[exp] = 1'b0;
      end
      req  = '0;
      m_rr = 1;
      @(negedge clk);
   endtask

   task automatic test_operand_stability;
      int c;
      set_ops(0, 8'd200, 8'd7);
      req = 4'b0001;
      repeat (3) @(negedge clk);
      set_ops(0, 8'd5, 8'd3);
      req = 4'b0000;
      wait_done(c);
      checks++; if (c + 3 != 9)         begin errors++; $display("FAIL stab_lat: got %0d want 9", c + 3); end
      checks++; if (done !== 4'b0001)   begin errors++; $display("FAIL stab_done: got %b want 0001", done); end
      checks++; if (quotient !== 8'd28) begin errors++; $display("FAIL stab_q: got %0d want 28", quotient); end
      checks++; if (remainder !== 8'd4) begin errors++; $display("FAIL stab_r: got %0d want 4", remainder); end
      m_rr = 1;
      @(negedge clk);
   endtask

   task automatic test_reset_midop;
      int c;
      bit seen;
      logic [W-1:0] a, b;
      set_ops(1, 8'd77, 8'd5);
      req = 4'b0010;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      req   = '0;
      m_rr  = 0;
      checks++; if (done !== '0)      begin errors++; $display("FAIL rst_done: got %b want 0", done); end
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (quotient !== '0)  begin errors++; $display("FAIL rst_q: got %0d want 0", quotient); end
      checks++; if (remainder !== '0) begin errors++; $display("FAIL rst_r: got %0d want 0", remainder); end
      checks++; if (owner !== '0)     begin errors++; $display("FAIL rst_owner: got %0d want 0", owner); end
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done != 0) seen = 1'b1;
      end
      checks++; if (seen) begin errors++; $display("FAIL rst_no_done: got done pulse want none"); end
      a = W'($urandom);
      b = W'($urandom_range(1, 255));
      set_ops(2, a, b);
      req = 4'b0100;
      wait_done(c);
      checks++; if (c != 9)            begin errors++; $display("FAIL rst_next_lat: got %0d want 9", c); end
      checks++; if (owner !== OW'(2))  begin errors++; $display("FAIL rst_next_owner: got %0d want 2", owner); end
      checks++; if (done !== 4'b0100)  begin errors++; $display("FAIL rst_next_done: got %b want 0100", done); end
      checks++; if (quotient !== ref_q(a, b))  begin errors++; $display("FAIL rst_next_q: got %0d want %0d", quotient, ref_q(a, b)); end
      checks++; if (remainder !== ref_r(a, b)) begin errors++; $display("FAIL rst_next_r: got %0d want %0d", remainder, ref_r(a, b)); end
      req  = '0;
      m_rr = 3;
      @(negedge clk);
   endtask

   task automatic test_enable_stall;
      int c;
      set_ops(3, 8'd250, 8'd13);
      req = 4'b1000;
      repeat (3) @(negedge clk);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b want 1", busy); end
      enable = 1'b1;
      wait_done(c);
      checks++; if (c + 6 != 12)        begin errors++; $display("FAIL stall_lat: got %0d want 12", c + 6); end
      checks++; if (done !== 4'b1000)   begin errors++; $display("FAIL stall_done: got %b want 1000", done); end
      checks++; if (quotient !== 8'd19) begin errors++; $display("FAIL stall_q: got %0d want 19", quotient); end
      checks++; if (remainder !== 8'd3) begin errors++; $display("FAIL stall_r: got %0d want 3", remainder); end
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (done !== 4'b1000)   begin errors++; $display("FAIL stretch_done[%0d]: got %b want 1000", i, done); end
         checks++; if (quotient !== 8'd19) begin errors++; $display("FAIL stretch_q[%0d]: got %0d want 19", i, quotient); end
      end
      enable = 1'b1;
      req    = '0;
      m_rr   = 0;
      @(negedge clk);
      checks++; if (done !== '0)     begin errors++; $display("FAIL stretch_end_done: got %b want 0", done); end
      checks++; if (quotient !== '0) begin errors++; $display("FAIL stretch_end_q: got %0d want 0", quotient); end
      checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL stretch_end_busy: got %b want 0", busy); end
   endtask

   task automatic test_random;
      int c, exp;
      bit first;
      logic [T-1:0] mask;
      logic [W-1:0] av[T];
      logic [W-1:0] bv[T];
      for (int it = 0; it < 12; it++) begin
         @(negedge clk);
         mask = T'($urandom_range(1, (1 << T) - 1));
         for (int t = 0; t < T; t++) begin
            av[t] = W'($urandom);
            bv[t] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            set_ops(t, av[t], bv[t]);
         end
         req   = mask;
         first = 1'b1;
         while (mask != 0) begin
            exp = ref_pick(mask, m_rr);
            wait_done(c);
            checks++; if (c != (first ? 9 : 10)) begin errors++; $display("FAIL rand_lat[%0d]: got %0d want %0d", it, c, first ? 9 : 10); end
            checks++; if (owner !== OW'(exp))    begin errors++; $display("FAIL rand_owner[%0d]: got %0d want %0d", it, owner, exp); end
            checks++; if (done !== T'(1 << exp)) begin errors++; $display("FAIL rand_done[%0d]: got %b want %b", it, done, T'(1 << exp)); end
            checks++; if (quotient !== ref_q(av[exp], bv[exp]))  begin errors++; $display("FAIL rand_q[%0d]: got %0d want %0d", it, quotient, ref_q(av[exp], bv[exp])); end
            checks++; if (remainder !== ref_r(av[exp], bv[exp])) begin errors++; $display("FAIL rand_r[%0d]: got %0d want %0d", it, remainder, ref_r(av[exp], bv[exp])); end
            mask[exp] = 1'b0;
            req       = mask;
            m_rr      = (exp + 1) % T;
            first     = 1'b0;
         end
      end
      req = '0;
      @(negedge clk);
   endtask

   initial begin
      reset   = 1'b1;
      enable  = 1'b1;
      req     = '0;
      rs_flat = '0;
      rt_flat = '0;
      test_reset();
      test_single();
      test_div_zero();
      test_fairness();
      test_operand_stability();
      test_reset_midop();
      test_enable_stall();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
